// File: rtl/md_unit_iter.sv
// rtl/md_unit_iter.sv - HI/LO multiply/divide unit with iterative restoring divider
// Optional multiply-accumulate (ops 7..10) is built only when MD_ACCUM_EN is defined.
module md_unit_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_ACCUM_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d, dvs_q, dvs_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d;

  logic                 can_accept;
  logic                 is_mul, is_div, mul_sgn, div_sgn;
  logic                 acc_add, acc_sub;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod_full, mul_result;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       rem_shift, rem_trial;
  logic                 rem_ge;

  assign can_accept = (state_q == S_IDLE) && start_i && !cancel_i;

  always_comb begin
    is_mul  = 1'b0;
    mul_sgn = 1'b0;
    acc_add = 1'b0;
    acc_sub = 1'b0;
    unique case (op_i)
      OP_MULT:  begin is_mul = 1'b1; mul_sgn = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
`ifdef MD_ACCUM_EN
      OP_MADD:  begin is_mul = 1'b1; mul_sgn = 1'b1; acc_add = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; acc_add = 1'b1; end
      OP_MSUB:  begin is_mul = 1'b1; mul_sgn = 1'b1; acc_sub = 1'b1; end
      OP_MSUBU: begin is_mul = 1'b1; acc_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign is_div  = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign div_sgn = (op_i == OP_DIV);

  // Sign-extending to 2*WIDTH makes one unsigned multiplier serve both flavours.
  assign ext_a     = {{WIDTH{a_i[WIDTH-1] & mul_sgn}}, a_i};
  assign ext_b     = {{WIDTH{b_i[WIDTH-1] & mul_sgn}}, b_i};
  assign prod_full = ext_a * ext_b;

  assign abs_a = (div_sgn && a_i[WIDTH-1]) ? -a_i : a_i;
  assign abs_b = (div_sgn && b_i[WIDTH-1]) ? -b_i : b_i;

  assign rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign rem_ge    = rem_q[WIDTH] || (rem_shift >= {1'b0, dvs_q});
  assign rem_trial = rem_shift - {1'b0, dvs_q};

`ifdef MD_ACCUM_EN
  logic [1:0] acc_q, acc_d;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) acc_q <= 2'b00;
    else           acc_q <= acc_d;
  end

  always_comb begin
    acc_d = acc_q;
    if (can_accept && is_mul) acc_d = {acc_sub, acc_add};
  end

  // {hi,lo} is taken at the write edge, not at accept.
  always_comb begin
    unique case (acc_q)
      2'b01:   mul_result = {hi_q, lo_q} + prod_q;
      2'b10:   mul_result = {hi_q, lo_q} - prod_q;
      default: mul_result = prod_q;
    endcase
  end
`else
  assign mul_result = prod_q;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (can_accept && is_mul)      state_d = S_MUL;
        else if (can_accept && is_div) state_d = S_DIV;
      end
      S_MUL: if (cancel_i || cnt_q == MUL_LAST) state_d = S_IDLE;
      S_DIV: if (cancel_i || cnt_q == DIV_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    prod_d = prod_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    bz_d   = bz_q;
    unique case (state_q)
      S_IDLE: begin
        if (can_accept) begin
          cnt_d = '0;
          if (op_i == OP_MTHI) hi_d = a_i;
          if (op_i == OP_MTLO) lo_d = a_i;
          if (is_mul) prod_d = prod_full;
          if (is_div) begin
            dvd_d  = abs_a;
            dvs_d  = abs_b;
            rem_d  = '0;
            qneg_d = div_sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_d = div_sgn && a_i[WIDTH-1];
            bz_d   = (b_i == '0);
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + CW'(1);
        if (!cancel_i && cnt_q == MUL_LAST) {hi_d, lo_d} = mul_result;
      end
      S_DIV: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q != DIV_LAST) begin
          // Quotient bits shift into the dividend register as it drains.
          rem_d = rem_ge ? rem_trial : rem_shift;
          dvd_d = {dvd_q[WIDTH-2:0], rem_ge};
        end else if (!cancel_i && !bz_q) begin
          lo_d = qneg_q ? -dvd_q : dvd_q;
          hi_d = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      prod_q <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      bz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      prod_q <= prod_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      bz_q   <= bz_d;
    end
  end

endmodule

// File: tb/tb_md_unit_iter.sv
// tb/tb_md_unit_iter.sv - directed self-checking bench for md_unit_iter
module tb_md_unit_iter;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        cancel_i = 1'b0;
  logic        busy_o;
  logic [31:0] hi_o, lo_o;

  int tests = 0;
  int fails = 0;

  md_unit_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .cancel_i(cancel_i), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic do_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk_i);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 0;
    while (busy_o === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset;
    reset_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_o); end
    tests++; if (hi_o !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", hi_o); end
    tests++; if (lo_o !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", lo_o); end
    reset_ni = 1'b1;
  endtask

  task automatic test_mult;
    int c;
    do_cmd(4'd1, 32'hFFFFFFFE, 32'd3, c);
    tests++; if (c != 5) begin fails++; $display("FAIL mult_cycles got %0d want 5", c); end
    tests++; if (hi_o !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi got %h want ffffffff", hi_o); end
    tests++; if (lo_o !== 32'hFFFFFFFA) begin fails++; $display("FAIL mult_lo got %h want fffffffa", lo_o); end
    do_cmd(4'd2, 32'hFFFFFFFE, 32'd3, c);
    tests++; if (hi_o !== 32'h2) begin fails++; $display("FAIL multu_hi got %h want 2", hi_o); end
    tests++; if (lo_o !== 32'hFFFFFFFA) begin fails++; $display("FAIL multu_lo got %h want fffffffa", lo_o); end
  endtask

  task automatic test_div;
    int c;
    do_cmd(4'd3, 32'hFFFFFFF9, 32'd2, c);
    tests++; if (c != 33) begin fails++; $display("FAIL div_cycles got %0d want 33", c); end
    tests++; if (lo_o !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo got %h want fffffffd", lo_o); end
    tests++; if (hi_o !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi got %h want ffffffff", hi_o); end
    do_cmd(4'd4, 32'd7, 32'd2, c);
    tests++; if (lo_o !== 32'd3) begin fails++; $display("FAIL divu_lo got %h want 3", lo_o); end
    tests++; if (hi_o !== 32'd1) begin fails++; $display("FAIL divu_hi got %h want 1", hi_o); end
    do_cmd(4'd3, 32'd100, 32'hFFFFFFF9, c);
    tests++; if (lo_o !== 32'hFFFFFFF2) begin fails++; $display("FAIL div_negb_lo got %h want fffffff2", lo_o); end
    tests++; if (hi_o !== 32'd2) begin fails++; $display("FAIL div_negb_hi got %h want 2", hi_o); end
    do_cmd(4'd3, 32'h80000000, 32'hFFFFFFFF, c);
    tests++; if (lo_o !== 32'h80000000) begin fails++; $display("FAIL div_min_lo got %h want 80000000", lo_o); end
    tests++; if (hi_o !== 32'h0) begin fails++; $display("FAIL div_min_hi got %h want 0", hi_o); end
  endtask

  task automatic test_div_zero;
    int c;
    do_cmd(4'd5, 32'h11, 32'h0, c);
    do_cmd(4'd6, 32'h22, 32'h0, c);
    do_cmd(4'd4, 32'd5, 32'd0, c);
    tests++; if (c != 33) begin fails++; $display("FAIL divz_cycles got %0d want 33", c); end
    tests++; if (hi_o !== 32'h11) begin fails++; $display("FAIL divz_hi got %h want 11", hi_o); end
    tests++; if (lo_o !== 32'h22) begin fails++; $display("FAIL divz_lo got %h want 22", lo_o); end
  endtask

  task automatic test_move;
    int c;
    @(negedge clk_i);
    op_i = 4'd5; a_i = 32'h55; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    tests++; if (hi_o !== 32'h55) begin fails++; $display("FAIL mthi_hi got %h want 55", hi_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL mthi_busy got %b want 0", busy_o); end
    // MTLO while a multiply is in flight must be dropped.
    op_i = 4'd1; a_i = 32'd2; b_i = 32'd3; start_i = 1'b1;
    @(negedge clk_i);
    op_i = 4'd6; a_i = 32'h1234; start_i = 1'b1;
    c = 1;
    @(negedge clk_i);
    start_i = 1'b0;
    while (busy_o === 1'b1 && c < 200) begin c++; @(negedge clk_i); end
    tests++; if (c != 5) begin fails++; $display("FAIL mtlo_busy_cycles got %0d want 5", c); end
    tests++; if (lo_o !== 32'd6) begin fails++; $display("FAIL mtlo_busy_lo got %h want 6", lo_o); end
    tests++; if (hi_o !== 32'd0) begin fails++; $display("FAIL mtlo_busy_hi got %h want 0", hi_o); end
    // cancel in IDLE suppresses a simultaneous start.
    op_i = 4'd5; a_i = 32'hDEAD; start_i = 1'b1; cancel_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; cancel_i = 1'b0;
    tests++; if (hi_o !== 32'd0) begin fails++; $display("FAIL idle_cancel_hi got %h want 0", hi_o); end
  endtask

  task automatic test_cancel;
    int c;
    @(negedge clk_i);
    op_i = 4'd3; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    c = 0;
    while (busy_o === 1'b1 && c < 10) begin c++; if (c < 10) @(negedge clk_i); end
    tests++; if (c != 10) begin fails++; $display("FAIL cancel_pre_busy got %0d want 10", c); end
    cancel_i = 1'b1;
    @(negedge clk_i);
    cancel_i = 1'b0;
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL cancel_busy got %b want 0", busy_o); end
    tests++; if (lo_o !== 32'd6 || hi_o !== 32'd0) begin fails++; $display("FAIL cancel_hilo got %h/%h want 0/6", hi_o, lo_o); end
    op_i = 4'd1; a_i = 32'd4; b_i = 32'd5; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    c = 0;
    while (busy_o === 1'b1 && c < 200) begin c++; @(negedge clk_i); end
    tests++; if (c != 5) begin fails++; $display("FAIL post_cancel_cycles got %0d want 5", c); end
    tests++; if (lo_o !== 32'd20 || hi_o !== 32'd0) begin fails++; $display("FAIL post_cancel_hilo got %h/%h want 0/14", hi_o, lo_o); end
  endtask

  task automatic test_accum;
    int c;
`ifdef MD_ACCUM_EN
    do_cmd(4'd5, 32'h0, 32'h0, c);
    do_cmd(4'd6, 32'hFFFFFFFF, 32'h0, c);
    do_cmd(4'd8, 32'd1, 32'd1, c);
    tests++; if (c != 5) begin fails++; $display("FAIL maddu_cycles got %0d want 5", c); end
    tests++; if (hi_o !== 32'd1 || lo_o !== 32'd0) begin fails++; $display("FAIL maddu_hilo got %h/%h want 1/0", hi_o, lo_o); end
    do_cmd(4'd5, 32'h0, 32'h0, c);
    do_cmd(4'd6, 32'h0, 32'h0, c);
    do_cmd(4'd9, 32'd1, 32'd2, c);
    tests++; if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFE) begin fails++; $display("FAIL msub_hilo got %h/%h want ffffffff/fffffffe", hi_o, lo_o); end
`else
    @(negedge clk_i);
    op_i = 4'd7; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL op7_busy got %b want 0", busy_o); end
    repeat (6) @(negedge clk_i);
    tests++; if (lo_o !== 32'd20 || hi_o !== 32'd0) begin fails++; $display("FAIL op7_hilo got %h/%h want 0/14", hi_o, lo_o); end
    c = 0;
`endif
  endtask

  task automatic test_async_reset;
    int c;
    do_cmd(4'd5, 32'h77, 32'h0, c);
    @(negedge clk_i);
    op_i = 4'd3; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL arst_pre_busy got %b want 1", busy_o); end
    #1 reset_ni = 1'b0;
    #1;
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL arst_busy got %b want 0", busy_o); end
    tests++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin fails++; $display("FAIL arst_hilo got %h/%h want 0/0", hi_o, lo_o); end
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_move;
    test_cancel;
    test_accum;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_unit_iter.md
Name: md_unit_iter

Overview:
- Parametrised HI/LO multiply/divide unit for the pipelined MIPS core; successor to the fixed 32-bit, fixed-latency MULT/DIV block.
- Adds generic operand width, configurable multiply latency, a true iterative radix-2 restoring divider, a cancel input for exception flush, and optional multiply-accumulate (MADD/MSUB).
- Sits beside the ALU in EX. The stall unit watches busy; HI/LO feed MFHI/MFLO.

Parameters:
- WIDTH, 32: operand, HI and LO width. Must be at least 2.
- MUL_LAT, 5: multiply busy cycles. Must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled on the rising edge.
- op  in  4  command code, valid with start.
- a  in  WIDTH  operand A; also the MTHI/MTLO data.
- b  in  WIDTH  operand B.
- cancel  in  1  aborts the in-flight operation (exception flush).
- busy  out  1  operation in flight (registered).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset:
  - reset low asynchronously clears hi, lo, busy, the state machine and all datapath registers to 0.
  - Reset mid-operation discards the operation.
- op encoding:
  - 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU.
  - Any other code is a no-op.
- State machine: IDLE, MUL, DIV. busy is 1 exactly when the state is not IDLE.
- Commands are accepted only in IDLE. start while busy is ignored, including MTHI/MTLO; the pipeline guarantees a stall.
- MTHI/MTLO: at the accepting edge, hi<=a or lo<=a. No busy cycle. A command may be accepted on the following edge.
- Multiply (MULT/MULTU/MADD*/MSUB*):
  - At accept edge T0, latch the 2*WIDTH product: signed for MULT/MADD/MSUB, unsigned for *U variants. Enter MUL with a counter.
  - At edge T0+MUL_LAT, write {hi,lo}. busy falls at the same edge, so busy is high for exactly MUL_LAT cycles.
  - MADD*/MSUB* write {hi,lo} plus or minus the product. The {hi,lo} value used is the one at the write edge. Arithmetic wraps modulo 2^(2*WIDTH).
- Divide (DIV/DIVU):
  - At T0, latch |a|, |b| (raw values for DIVU), the quotient sign and the remainder sign. Enter DIV.
  - Edges T0+1 to T0+WIDTH: one restoring shift/subtract step each. The remainder register is WIDTH+1 bits.
  - At edge T0+WIDTH+1, apply sign fix and write lo<=quotient, hi<=remainder. busy falls at this edge, so busy is high for WIDTH+1 cycles.
  - Quotient truncates toward zero. The remainder takes the sign of the dividend.
  - MIN/-1 yields lo=MIN, hi=0.
  - b==0 still runs WIDTH+1 cycles but leaves hi and lo unchanged.
- cancel:
  - Any cycle when busy: the next edge returns to IDLE with hi/lo unchanged, and busy falls.
  - cancel on the completion edge wins: no write.
  - cancel in IDLE blocks acceptance of a start at the same edge.
- Pipeline visibility:
  - hi/lo are readable at any time. Their value during busy is the pre-operation value.
  - The pipeline must not issue MF* while busy.

Optional Feature:
- Macro MD_ACCUM_EN.
- Defined: ops 7 to 10 perform MADD/MADDU/MSUB/MSUBU as described.
- Undefined: ops 7 to 10 are no-ops (not accepted, busy stays 0), and the accumulate adder/subtractor is not synthesised.

Test Plan (WIDTH=32, MUL_LAT=5):
- MULT a=0xFFFFFFFE(-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x2, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy high 33 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU b=0 with hi=0x11, lo=0x22 beforehand -> 33 busy cycles; hi=0x11, lo=0x22 unchanged.
- MTLO a=0x1234 while a MULT is busy -> ignored, lo receives the product. MTHI a=0x55 in IDLE -> hi=0x55 next edge, busy stays 0.
- DIV started, cancel at busy cycle 10 -> busy low next edge, hi/lo unchanged. A new MULT accepted the following cycle completes normally.
- With MD_ACCUM_EN: hi=0, lo=0xFFFFFFFF, then MADDU a=1, b=1 -> hi=1, lo=0. MSUB a=1, b=2 from 0 -> hi=lo=0xFFFFFFFF/0xFFFFFFFE. Without the macro: op 7 leaves busy 0 and hi/lo unchanged.
- Assert reset low mid-divide -> busy, hi and lo clear to 0 immediately (asynchronously).
